// File: rtl/twos_comp_serial_decoder_pkg.sv
// Shared types and sizing helpers for the bit-serial two's-complement decoder.
package twos_dec_pkg;

  // Controller states: wait for a word, walk its bits, present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Bit-counter width; WIDTH >= 2 always gives at least one bit.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/twos_comp_serial_decoder_fa_cell.sv
// Single-bit full adder made of two half adders and an OR, the same cell
// the parallel complement encoder chains together.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // First half adder: a + b.
  assign ha0_s = a ^ b;
  assign ha0_c = a & b;

  // Second half adder folds in the carry; either half can produce carry-out.
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;
  assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/twos_comp_serial_decoder.sv
// Bit-serial two's-complement to sign/magnitude decoder.
// One full-adder cell plus a carry flop walk the operand LSB first over
// WIDTH cycles: magnitude = (x XOR sign) + sign, final carry dropped.
// Optional build macro TWOS_DEC_FAST_POS_EN: non-negative operands skip the
// serial walk and are presented one edge after acceptance.
module twos_comp_serial_decoder
  import twos_dec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef TWOS_DEC_FAST_POS_EN
  localparam bit FAST_POS = 1'b1;
`else
  localparam bit FAST_POS = 1'b0;
`endif

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic [WIDTH-1:0] mag_q,       mag_d;
  logic             sign_q,      sign_d;
  logic             carry_q,     carry_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             out_valid_q, out_valid_d;

  logic x_bit;
  logic fa_a;
  logic fa_s;
  logic fa_cout;

  // Current operand bit, conditionally inverted by the latched sign.
  assign x_bit = shreg_q[cnt_q];
  assign fa_a  = x_bit ^ sign_q;

  fa_cell u_fa (
    .a    (fa_a),
    .b    (1'b0),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state logic for the controller, datapath and output registers.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    mag_d       = mag_q;
    sign_d      = sign_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          sign_d  = in_data[WIDTH-1];
          // Carry seeded with the sign supplies the "+1" for negatives.
          carry_d = in_data[WIDTH-1];
          cnt_d   = '0;
          mag_d   = '0;
          state_d = SHIFT;
          if (FAST_POS && !in_data[WIDTH-1]) begin
            // A non-negative word is already its own magnitude.
            mag_d       = in_data;
            sign_d      = 1'b0;
            carry_d     = 1'b0;
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        mag_d[cnt_q] = fa_s;
        carry_d      = fa_cout;
        if (cnt_q == LAST_BIT) begin
          // Last carry-out is dropped: -2^(W-1) maps to 2^(W-1) unsigned.
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Result holds until consumed; IDLE is always visited before the
        // next accept.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and result registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      sign_q      <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      sign_q      <= sign_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand shift register; only read after a fresh load, so no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_sign  = sign_q;
  assign out_mag   = mag_q;

endmodule

// File: tb/tb_twos_comp_serial_decoder.sv
// Directed bench for twos_comp_serial_decoder (WIDTH=4) with a scoreboard.
// Adapts expected latency to the TWOS_DEC_FAST_POS_EN build macro.
module tb_twos_comp_serial_decoder;

  localparam int W = 4;

`ifdef TWOS_DEC_FAST_POS_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;

  typedef struct {
    logic         sign;
    logic [W-1:0] mag;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  twos_comp_serial_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: magnitude is the word itself or its two's-complement negation.
  function automatic exp_t model(input logic [W-1:0] d);
    exp_t         e;
    logic [W-1:0] neg;
    neg    = ~d + 1'b1;
    e.sign = d[W-1];
    e.mag  = d[W-1] ? neg : d;
    e.lat  = (FAST && !d[W-1]) ? 0 : W;
    return e;
  endfunction

  // Offer a word and return #1 after the accepting edge.
  task automatic send(input logic [W-1:0] d);
    int guard = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    sb.push_back(model(d));
  endtask

  // Wait for the result, counting edges after the accept edge.
  task automatic collect(input string tag);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sbsize"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_lat"}, lat, e.lat);
      check({tag, "_sign"}, out_sign, e.sign);
      check({tag, "_mag"}, out_mag, e.mag);
    end
    check({tag, "_busy"}, in_ready, 0);
  endtask

  // One edge with out_ready high completes the output handshake.
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_vld_clr"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_sign", out_sign, 0);
    check("rst_out_mag", out_mag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Positive, negative, most-negative and zero operands.
    send(4'b0101); collect("pos5");  release_out("pos5");
    send(4'b1011); collect("neg5");  release_out("neg5");
    send(4'b1000); collect("neg8");  release_out("neg8");
    send(4'b0000); collect("zero");  release_out("zero");

    // Consumer stall: outputs frozen and a new word is not taken.
    out_ready = 1'b0;
    send(4'b1111);
    collect("stall");
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        in_data  = 4'b0101;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_sign", out_sign, 1);
      check("stall_mag", out_mag, 4'b0001);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out("stall");
    check("stall_sb_empty", sb.size(), 0);

    // Reset during the second SHIFT cycle drops the word immediately.
    send(4'b1010);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_sign", out_sign, 0);
    check("midrst_out_mag", out_mag, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    send(4'b0011); collect("after_rst"); release_out("after_rst");

    // Full sweep of every operand value.
    for (int v = 0; v < 16; v++) begin
      send(W'(v));
      collect("sweep");
      release_out("sweep");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
